// File: rtl/inst_cache_pkg.sv
// Shared parameters and FSM encoding for the direct-mapped instruction cache.
// Included by inst_cache and icache_fill_ctrl.
package inst_cache_pkg;

  localparam int WORD_SIZE    = 32;
  localparam int BLOCK_SIZE   = 16;
  localparam int OFFSET_BITS  = $clog2(BLOCK_SIZE);
  localparam int NUM_LINES    = 8;
  localparam int MISS_LATENCY = 4;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_FILL = 1'b1
  } ic_state_t;

endpackage

// File: rtl/icache_fill_ctrl.sv
// Miss handling for inst_cache: the IDLE/FILL state machine, the memory latency
// counter, the latched block address and the one-cycle line write strobe.
module icache_fill_ctrl
  import inst_cache_pkg::*;
#(
  parameter int WORD_SIZE    = inst_cache_pkg::WORD_SIZE,
  parameter int MISS_LATENCY = inst_cache_pkg::MISS_LATENCY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss,
  input  logic [WORD_SIZE-1:0] blk_addr,
  output logic                 in_fill,
  output logic [WORD_SIZE-1:0] fill_addr,
  output logic                 fill_en
);

  localparam int CNT_W = $clog2(MISS_LATENCY + 1);

  ic_state_t        state;
  ic_state_t        next_state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IC_IDLE;
      cnt       <= '0;
      fill_addr <= '0;
    end else begin
      state <= next_state;
      // Counter is armed on the miss cycle so the first FILL cycle sees MISS_LATENCY-1.
      if (state == IC_IDLE && miss) begin
        fill_addr <= blk_addr;
        cnt       <= CNT_W'(MISS_LATENCY - 1);
      end else if (state == IC_FILL && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    fill_en    = 1'b0;
    case (state)
      IC_IDLE: begin
        if (miss) next_state = IC_FILL;
      end
      IC_FILL: begin
        if (cnt == '0) begin
          fill_en    = 1'b1;
          next_state = IC_IDLE;
        end
      end
      default: next_state = IC_IDLE;
    endcase
  end

  assign in_fill = (state == IC_FILL);

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: zero-latency hits, fixed-latency whole-line
// refill from inst_memory, plus free-running hit/miss counters.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int WORD_SIZE    = inst_cache_pkg::WORD_SIZE,
  parameter int BLOCK_SIZE   = inst_cache_pkg::BLOCK_SIZE,
  parameter int NUM_LINES    = inst_cache_pkg::NUM_LINES,
  parameter int MISS_LATENCY = inst_cache_pkg::MISS_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req,
  input  logic [WORD_SIZE-1:0]            pc,
  output logic [WORD_SIZE-1:0]            inst,
  output logic                            inst_valid,
  output logic                            stall,
  output logic [WORD_SIZE-1:0]            mem_addr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags     [NUM_LINES];
  logic [WORD_SIZE-1:0] data_mem [NUM_LINES][BLOCK_SIZE];

  logic [OFF_W-1:0]     offset;
  logic [IDX_W-1:0]     index;
  logic [TAG_W-1:0]     tag;
  logic [WORD_SIZE-1:0] blk_addr;
  logic [WORD_SIZE-1:0] fill_addr;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 in_fill;
  logic                 fill_en;
  logic                 hit;
  logic                 miss;

  assign offset   = pc[OFF_W-1:0];
  assign index    = pc[OFF_W +: IDX_W];
  assign tag      = pc[WORD_SIZE-1 -: TAG_W];
  assign blk_addr = {pc[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
  assign fill_idx = fill_addr[OFF_W +: IDX_W];
  assign fill_tag = fill_addr[WORD_SIZE-1 -: TAG_W];

  // Lookups only happen in IDLE; during a fill pc and req are ignored entirely.
  assign hit  = req && !in_fill && valid[index] && (tags[index] == tag);
  assign miss = req && !in_fill && !hit;

  icache_fill_ctrl #(
    .WORD_SIZE   (WORD_SIZE),
    .MISS_LATENCY(MISS_LATENCY)
  ) u_fill_ctrl (
    .clk      (clk),
    .reset    (reset),
    .miss     (miss),
    .blk_addr (blk_addr),
    .in_fill  (in_fill),
    .fill_addr(fill_addr),
    .fill_en  (fill_en)
  );

  always_comb begin
    inst       = '0;
    inst_valid = hit;
    stall      = in_fill || miss;
    mem_addr   = in_fill ? fill_addr : blk_addr;
    if (hit) inst = data_mem[index][offset];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Word 0 of the memory block sits in the MSBs.
  always_ff @(posedge clk) begin
    if (fill_en && !reset) begin
      tags[fill_idx] <= fill_tag;
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        data_mem[fill_idx][i] <= mem_block[WORD_SIZE*(BLOCK_SIZE-i)-1 -: WORD_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)  hit_count  <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed testbench for inst_cache with a line-residency model checked every cycle
// and literal expectations for the hand-worked scenarios.
module tb_inst_cache;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic [31:0]  pc;
  logic [31:0]  inst;
  logic         inst_valid;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [511:0] mem_block;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  inst_cache #(
    .WORD_SIZE   (32),
    .BLOCK_SIZE  (16),
    .NUM_LINES   (8),
    .MISS_LATENCY(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .pc        (pc),
    .inst      (inst),
    .inst_valid(inst_valid),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_block (mem_block),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Memory holds A000_0000 + address; word 0 of the block goes in the MSBs.
  always_comb begin
    mem_block = '0;
    for (int i = 0; i < 16; i++) begin
      mem_block[32*(16-i)-1 -: 32] = 32'hA000_0000 + mem_addr + 32'(i);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] p);
    @(posedge clk);
    #1;
    req = r;
    pc  = p;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_fill(output int n, output logic [31:0] lsw);
    n   = 0;
    lsw = '0;
    while (stall === 1'b1 && n < 20) begin
      n++;
      lsw = mem_block[31:0];
      step();
    end
  endtask

  // Model: which block each line holds, remaining memory wait, and counters.
  bit          m_valid [8];
  int unsigned m_tag   [8];
  int          m_busy;
  logic [31:0] m_fill_addr;
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  always @(negedge clk) begin
    int unsigned idx;
    bit          m_hit;
    logic [31:0] e_inst;
    logic [31:0] e_mem;
    logic        e_stall;
    idx   = (pc >> 4) & 32'd7;
    m_hit = (m_busy == 0) && req && m_valid[idx] && (m_tag[idx] == (pc >> 7));
    if (m_busy > 0) begin
      e_stall = 1'b1;
      e_inst  = '0;
      e_mem   = m_fill_addr;
    end else begin
      e_stall = req && !m_hit;
      e_inst  = m_hit ? 32'hA000_0000 + pc : 32'h0;
      e_mem   = pc & ~32'hF;
    end
    if (check_en) begin
      checkOutput("model_stall", {31'd0, stall}, {31'd0, e_stall});
      checkOutput("model_inst_valid", {31'd0, inst_valid}, {31'd0, m_hit});
      checkOutput("model_inst", inst, e_inst);
      checkOutput("model_mem_addr", mem_addr, e_mem);
      checkOutput("model_hit_count", hit_count, m_hits);
      checkOutput("model_miss_count", miss_count, m_misses);
    end
    if (reset) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_busy   = 0;
      m_hits   = '0;
      m_misses = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_valid[(m_fill_addr >> 4) & 32'd7] = 1'b1;
        m_tag[(m_fill_addr >> 4) & 32'd7]   = m_fill_addr >> 7;
      end
    end else if (m_hit) begin
      m_hits++;
    end else if (req) begin
      m_misses++;
      m_busy      = LAT;
      m_fill_addr = pc & ~32'hF;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    logic [31:0] lsw;
    logic [31:0] hc;
    logic [31:0] mc;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_busy      = 0;
    m_fill_addr = '0;
    m_hits      = '0;
    m_misses    = '0;
    reset = 1'b1;
    req   = 1'b0;
    pc    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    check_en = 1'b1;
    #1;
    checkOutput("reset_stall", {31'd0, stall}, 32'd0);
    checkOutput("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_hit_count", hit_count, 32'd0);
    checkOutput("reset_miss_count", miss_count, 32'd0);

    // Cold miss on 0x10 then the hit.
    applyStimulus(1'b1, 32'h10);
    checkOutput("cold_mem_addr", mem_addr, 32'h10);
    wait_fill(n, lsw);
    checkOutput("cold_stall_cycles", n, 32'd5);
    checkOutput("cold_inst", inst, 32'hA000_0010);
    checkOutput("cold_inst_valid", {31'd0, inst_valid}, 32'd1);

    // Rest of the line hits back-to-back.
    for (int a = 32'h11; a <= 32'h1F; a++) begin
      applyStimulus(1'b1, 32'(a));
      if (a == 32'h11) begin
        checkOutput("cold_hit_count", hit_count, 32'd1);
        checkOutput("cold_miss_count", miss_count, 32'd1);
      end
      checkOutput("seq_stall", {31'd0, stall}, 32'd0);
      checkOutput("seq_inst", inst, 32'hA000_0000 + 32'(a));
    end
    applyStimulus(1'b0, 32'h0);
    checkOutput("seq_hit_count", hit_count, 32'd16);
    checkOutput("seq_miss_count", miss_count, 32'd1);

    // Last word of a block comes from the LSBs of mem_block.
    applyStimulus(1'b1, 32'h2F);
    wait_fill(n, lsw);
    checkOutput("order_stall_cycles", n, 32'd5);
    checkOutput("order_inst", inst, 32'hA000_002F);
    checkOutput("order_block_lsw", lsw, 32'hA000_002F);

    // Conflict on index 1.
    applyStimulus(1'b1, 32'h10);
    checkOutput("conf_resident_hit", {31'd0, inst_valid}, 32'd1);
    applyStimulus(1'b1, 32'h90);
    checkOutput("conf_stall", {31'd0, stall}, 32'd1);
    checkOutput("conf_mem_addr", mem_addr, 32'h90);
    wait_fill(n, lsw);
    checkOutput("conf_stall_cycles", n, 32'd5);
    checkOutput("conf_inst", inst, 32'hA000_0090);
    applyStimulus(1'b1, 32'h10);
    checkOutput("conf_evicted_stall", {31'd0, stall}, 32'd1);
    wait_fill(n, lsw);
    checkOutput("conf_refill_inst", inst, 32'hA000_0010);
    applyStimulus(1'b0, 32'h0);
    checkOutput("conf_miss_count", miss_count, 32'd4);

    // Reset on the second FILL cycle aborts the fill.
    applyStimulus(1'b1, 32'h40);
    checkOutput("abort_mem_addr", mem_addr, 32'h40);
    step();
    step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = 1'b0;
    #1;
    checkOutput("abort_stall", {31'd0, stall}, 32'd0);
    checkOutput("abort_hit_count", hit_count, 32'd0);
    checkOutput("abort_miss_count", miss_count, 32'd0);
    applyStimulus(1'b1, 32'h40);
    wait_fill(n, lsw);
    checkOutput("abort_restall_cycles", n, 32'd5);
    checkOutput("abort_inst", inst, 32'hA000_0040);

    // Idle with arbitrary pc.
    applyStimulus(1'b0, 32'h0);
    hc = hit_count;
    mc = miss_count;
    checkOutput("idle_base_hits", hc, 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, $urandom);
      checkOutput("idle_stall", {31'd0, stall}, 32'd0);
      checkOutput("idle_inst_valid", {31'd0, inst_valid}, 32'd0);
      checkOutput("idle_inst", inst, 32'd0);
    end
    step();
    checkOutput("idle_hit_count", hit_count, hc);
    checkOutput("idle_miss_count", miss_count, mc);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
